// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I shared opcodes, ALU encoding, immediate types and immediate generator
package rv32i_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic logic [RV_XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    logic [RV_XLEN-1:0] imm;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt, input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32-entry register file, 2 read / 1 write, x0 hardwired to zero
// Optional write-through read bypass: RV32I_WB_BYPASS_EN
module rv32i_regfile #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]       rdata1_o,
  output logic [XLEN-1:0]       rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != '0) begin
`ifdef RV32I_WB_BYPASS_EN
      rdata1_o = (wr_en && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
`else
      rdata1_o = regs_q[raddr1_i];
`endif
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != '0) begin
`ifdef RV32I_WB_BYPASS_EN
      rdata2_o = (wr_en && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
`else
      rdata2_o = regs_q[raddr2_i];
`endif
    end
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: IF/ID register, regfile, decoder, load-use stall, ID/EX register
// Optional regfile write-through bypass: RV32I_WB_BYPASS_EN
module id_stage
  import rv32i_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              REG_ADDR_W = 5,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       instr_in,
  input  logic                  if_valid,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  stall_if,
  output logic                  id_valid,
  output logic [XLEN-1:0]       id_pc,
  output logic [XLEN-1:0]       id_rs1_data,
  output logic [XLEN-1:0]       id_rs2_data,
  output logic [XLEN-1:0]       id_imm,
  output logic [REG_ADDR_W-1:0] id_rs1,
  output logic [REG_ADDR_W-1:0] id_rs2,
  output logic [REG_ADDR_W-1:0] id_rd,
  output logic [2:0]            id_funct3,
  output logic [3:0]            id_alu_op,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  output logic                  id_alu_src,
  output logic                  id_illegal
);

  logic            ifid_valid_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [31:0]     ifid_instr_q;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd_field;
  logic [XLEN-1:0]       rs1_data, rs2_data;

  assign opcode   = ifid_instr_q[6:0];
  assign funct3   = ifid_instr_q[14:12];
  assign rs1      = ifid_instr_q[19:15];
  assign rs2      = ifid_instr_q[24:20];
  assign rd_field = ifid_instr_q[11:7];

  alu_op_e   dec_alu_op;
  imm_type_e dec_imm_type;
  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic dec_alu_src, dec_illegal, dec_use_rs1, dec_use_rs2, dec_no_rd;

  always_comb begin
    dec_alu_op    = ALU_ADD;
    dec_imm_type  = IMM_NONE;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_alu_src   = 1'b0;
    dec_illegal   = 1'b0;
    dec_use_rs1   = 1'b0;
    dec_use_rs2   = 1'b0;
    dec_no_rd     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm_type = IMM_U; dec_alu_op = ALU_PASSB; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        dec_imm_type = IMM_U; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
      end
      OPC_JAL: begin
        dec_imm_type = IMM_J; dec_reg_write = 1'b1; dec_jump = 1'b1; dec_alu_src = 1'b1;
      end
      OPC_JALR: begin
        dec_imm_type = IMM_I; dec_reg_write = 1'b1; dec_jump = 1'b1; dec_alu_src = 1'b1;
        dec_use_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_type = IMM_B; dec_alu_op = ALU_SUB; dec_branch = 1'b1; dec_no_rd = 1'b1;
        dec_use_rs1  = 1'b1; dec_use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm_type = IMM_I; dec_reg_write = 1'b1; dec_mem_read = 1'b1; dec_alu_src = 1'b1;
        dec_use_rs1  = 1'b1;
      end
      OPC_STORE: begin
        dec_imm_type = IMM_S; dec_mem_write = 1'b1; dec_alu_src = 1'b1; dec_no_rd = 1'b1;
        dec_use_rs1  = 1'b1; dec_use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_imm_type = IMM_I; dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_use_rs1 = 1'b1;
        dec_alu_op   = alu_from_funct3(funct3, ifid_instr_q[30], 1'b0);
      end
      OPC_OP: begin
        dec_reg_write = 1'b1; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
        dec_alu_op    = alu_from_funct3(funct3, ifid_instr_q[30], 1'b1);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  rv32i_regfile #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
    .clk      (clk),
    .rst      (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  // The load in ID/EX cannot forward in time to the instruction behind it.
  logic load_use, bubble;
  assign load_use = id_valid && id_mem_read && (id_rd != '0) && ifid_valid_q &&
                    ((dec_use_rs1 && (rs1 == id_rd)) || (dec_use_rs2 && (rs2 == id_rd)));
  assign stall_if = load_use && !flush;
  assign bubble   = flush || load_use || !ifid_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= '0;
    end else if (flush) begin
      ifid_valid_q <= 1'b0;
    end else if (!stall_if) begin
      ifid_valid_q <= if_valid;
      ifid_pc_q    <= pc_in;
      ifid_instr_q <= instr_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      id_valid     <= 1'b0;
      id_pc        <= RESET_PC;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_funct3    <= '0;
      id_alu_op    <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
      id_jump      <= 1'b0;
      id_alu_src   <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      id_valid     <= 1'b1;
      id_pc        <= ifid_pc_q;
      id_rs1_data  <= rs1_data;
      id_rs2_data  <= rs2_data;
      id_imm       <= gen_imm(ifid_instr_q, dec_imm_type);
      id_rs1       <= rs1;
      id_rs2       <= rs2;
      id_rd        <= dec_no_rd ? '0 : rd_field;
      id_funct3    <= funct3;
      id_alu_op    <= dec_alu_op;
      id_reg_write <= dec_reg_write;
      id_mem_read  <= dec_mem_read;
      id_mem_write <= dec_mem_write;
      id_branch    <= dec_branch;
      id_jump      <= dec_jump;
      id_alu_src   <= dec_alu_src;
      id_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed table-driven bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, wb_data;
  logic        if_valid, flush, wb_we;
  logic [4:0]  wb_rd;
  logic        stall_if, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in), .if_valid(if_valid),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_if(stall_if), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_alu_op(id_alu_op), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_src(id_alu_src), .id_illegal(id_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [6:0]  ctl;  // {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins; pc_in = pc; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  function automatic logic [6:0] ctl_now();
    return {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_illegal};
  endfunction

  initial begin
    vecs[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  32'h00000005, 4'd0,  7'b1000010}; // addi x1,x0,5
    vecs[1]  = '{32'h0000A103, 5'd2,  5'd1,  5'd0,  32'h00000000, 4'd0,  7'b1100010}; // lw x2,0(x1)
    vecs[2]  = '{32'hFE20AE23, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 4'd0,  7'b0010010}; // sw x2,-4(x1)
    vecs[3]  = '{32'hFE208CE3, 5'd0,  5'd1,  5'd2,  32'hFFFFFFF8, 4'd1,  7'b0001000}; // beq x1,x2,-8
    vecs[4]  = '{32'h123452B7, 5'd5,  5'd8,  5'd3,  32'h12345000, 4'd10, 7'b1000010}; // lui x5
    vecs[5]  = '{32'h010000EF, 5'd1,  5'd0,  5'd16, 32'h00000010, 4'd0,  7'b1000110}; // jal x1,16
    vecs[6]  = '{32'h001101B3, 5'd3,  5'd2,  5'd1,  32'h00000000, 4'd0,  7'b1000000}; // add
    vecs[7]  = '{32'h401101B3, 5'd3,  5'd2,  5'd1,  32'h00000000, 4'd1,  7'b1000000}; // sub
    vecs[8]  = '{32'h4030D213, 5'd4,  5'd1,  5'd3,  32'h00000403, 4'd7,  7'b1000010}; // srai
    vecs[9]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 32'h00000000, 4'd0,  7'b0000001}; // illegal
    vecs[10] = '{32'h0FF0000F, 5'd0,  5'd0,  5'd31, 32'h00000000, 4'd0,  7'b0000000}; // fence
    vecs[11] = '{32'h00001397, 5'd7,  5'd0,  5'd0,  32'h00001000, 4'd0,  7'b1000010}; // auipc
    vecs[12] = '{32'h00008067, 5'd0,  5'd1,  5'd0,  32'h00000000, 4'd0,  7'b1000110}; // jalr

    reset = 1'b1; pc_in = '0; instr_in = '0; if_valid = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_stall", 32'(stall_if), 32'd0);
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].instr, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'd1);
      chk($sformatf("v%0d_pc", i), id_pc, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_rd", i), 32'(id_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(id_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(id_rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
      chk($sformatf("v%0d_alu", i), 32'(id_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("v%0d_f3", i), 32'(id_funct3), 32'(vecs[i].instr[14:12]));
      chk($sformatf("v%0d_rs1d", i), id_rs1_data, 32'd0);
      chk($sformatf("v%0d_stall", i), 32'(stall_if), 32'd0);
    end

    // Write-back then read; x0 writes ignored
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0;
    issue(32'h00028333, 32'h200);
    chk("wb_rs1d", id_rs1_data, 32'hDEADBEEF);
    chk("wb_rs2d", id_rs2_data, 32'd0);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    issue(32'h00000333, 32'h204);
    chk("x0_rs1d", id_rs1_data, 32'd0);
    chk("x0_rs2d", id_rs2_data, 32'd0);

    // Same-cycle write of x5 while add x6,x5,x0 sits in IF/ID
    instr_in = 32'h00028333; pc_in = 32'h208; if_valid = 1'b1;
    tick();
    if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
    tick();
    wb_we = 1'b0;
`ifdef RV32I_WB_BYPASS_EN
    chk("bypass_rs1d", id_rs1_data, 32'hCAFEF00D);
`else
    chk("bypass_rs1d", id_rs1_data, 32'hDEADBEEF);
`endif

    // Load-use: lw x2,0(x1) then add x3,x2,x1
    instr_in = 32'h0000A103; pc_in = 32'h300; if_valid = 1'b1;
    tick();
    instr_in = 32'h001101B3; pc_in = 32'h304;
    tick();
    chk("lu_ld_issued", 32'(id_mem_read), 32'd1);
    chk("lu_stall", 32'(stall_if), 32'd1);
    tick();
    chk("lu_bubble", 32'(id_valid), 32'd0);
    chk("lu_stall_end", 32'(stall_if), 32'd0);
    if_valid = 1'b0;
    tick();
    chk("lu_add_valid", 32'(id_valid), 32'd1);
    chk("lu_add_pc", id_pc, 32'h304);
    chk("lu_add_rs1", 32'(id_rs1), 32'd2);
    chk("lu_add_rs2", 32'(id_rs2), 32'd1);
    chk("lu_add_rd", 32'(id_rd), 32'd3);

    // Flush during an active load-use stall
    instr_in = 32'h0000A103; pc_in = 32'h400; if_valid = 1'b1;
    tick();
    instr_in = 32'h001101B3; pc_in = 32'h404;
    tick();
    chk("fl_stall_pre", 32'(stall_if), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_if), 32'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("fl_idvalid", 32'(id_valid), 32'd0);
    chk("fl_pc", id_pc, 32'd0);
    tick();
    chk("fl_ifid_dead", 32'(id_valid), 32'd0);

    // Asynchronous reset mid-operation
    issue(32'h00500093, 32'h500);
    chk("ar_pre_valid", 32'(id_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    chk("ar_ctl", 32'(ctl_now()), 32'd0);
    chk("ar_imm", id_imm, 32'd0);
    tick();
    reset = 1'b0;
    issue(32'h00028333, 32'h600);
    chk("ar_x5_cleared", id_rs1_data, 32'd0);
    chk("ar_after_valid", 32'(id_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
